// File: rtl/pipelined_decode_stage_if.sv
// pipelined_decode_stage_if: fetch, write-back, flush and ID/EX signals of the decode stage
interface pipelined_decode_stage_if #(parameter int XLEN = 32);
   logic            if_valid;
   logic            if_ready;
   logic [31:0]     if_instr;
   logic [XLEN-1:0] if_pc;
   logic            flush;
   logic            wb_en;
   logic [4:0]      wb_addr;
   logic [XLEN-1:0] wb_data;
   logic            ex_valid;
   logic            ex_ready;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_rs1_data;
   logic [XLEN-1:0] ex_rs2_data;
   logic [XLEN-1:0] ex_imm;
   logic [4:0]      ex_rs1;
   logic [4:0]      ex_rs2;
   logic [4:0]      ex_rd;
   logic [6:0]      ex_opcode;
   logic [2:0]      ex_funct3;
   logic            ex_funct7_5;
   logic            ex_reg_write;
   logic            ex_mem_read;
   logic            ex_mem_write;
   logic            ex_illegal;
   logic            hazard_stall;
   modport master (
      output if_valid, if_instr, if_pc, flush, wb_en, wb_addr, wb_data, ex_ready,
      input  if_ready, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
             ex_rd, ex_opcode, ex_funct3, ex_funct7_5, ex_reg_write, ex_mem_read,
             ex_mem_write, ex_illegal, hazard_stall
   );
   modport slave (
      input  if_valid, if_instr, if_pc, flush, wb_en, wb_addr, wb_data, ex_ready,
      output if_ready, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
             ex_rd, ex_opcode, ex_funct3, ex_funct7_5, ex_reg_write, ex_mem_read,
             ex_mem_write, ex_illegal, hazard_stall
   );
endinterface

// File: rtl/pipelined_decode_stage.sv
// pipelined_decode_stage: RV32I/E decode with register file, ID/EX register, load-use interlock and write-back bypass
module pipelined_decode_stage #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter bit BYPASS = 1'b1
) (
   input logic                     clk,
   input logic                     reset,
   pipelined_decode_stage_if.slave bus
);
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic            funct7_5;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            illegal;
   } ex_t;
   logic [31:0]     ins;
   logic [6:0]      op;
   logic [4:0]      rs1, rs2, rd;
   logic            is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
   logic            known, use_rs1, use_rs2, has_rd, illegal, hazard, accept;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic [XLEN-1:0] rf_q [NREGS];
   logic [XLEN-1:0] rf_d [NREGS];
   ex_t             dec, ex_d, ex_q;
   always_comb begin
      ins       = bus.if_instr;
      op        = ins[6:0];
      rs1       = ins[19:15];
      rs2       = ins[24:20];
      rd        = ins[11:7];
      is_lui    = op == OP_LUI;
      is_auipc  = op == OP_AUIPC;
      is_jal    = op == OP_JAL;
      is_jalr   = op == OP_JALR;
      is_branch = op == OP_BRANCH;
      is_load   = op == OP_LOAD;
      is_store  = op == OP_STORE;
      is_opimm  = op == OP_OPIMM;
      is_op     = op == OP_OP;
      known     = is_lui || is_auipc || is_jal || is_jalr || is_branch || is_load || is_store || is_opimm || is_op;
      use_rs1   = is_jalr || is_branch || is_load || is_store || is_opimm || is_op;
      use_rs2   = is_branch || is_store || is_op;
      has_rd    = known && !is_branch && !is_store;
      // only indices the instruction actually uses can make it illegal on RV32E
      illegal   = !known || (use_rs1 && int'(rs1) >= NREGS) || (use_rs2 && int'(rs2) >= NREGS)
                  || (has_rd && int'(rd) >= NREGS);
      imm_i     = XLEN'($signed(ins[31:20]));
      imm_s     = XLEN'($signed({ins[31:25], ins[11:7]}));
      imm_b     = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      imm_u     = XLEN'($signed({ins[31:12], 12'b0}));
      imm_j     = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      imm       = (is_jalr || is_load || is_opimm) ? imm_i :
                  is_store                         ? imm_s :
                  is_branch                        ? imm_b :
                  (is_lui || is_auipc)             ? imm_u :
                  is_jal                           ? imm_j : '0;
   end
   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      for (int i = 1; i < NREGS; i++) begin
         if (int'(rs1) == i)
            rs1_data = (BYPASS && bus.wb_en && bus.wb_addr == rs1) ? bus.wb_data : rf_q[i];
         if (int'(rs2) == i)
            rs2_data = (BYPASS && bus.wb_en && bus.wb_addr == rs2) ? bus.wb_data : rf_q[i];
      end
   end
   always_comb begin
      for (int i = 0; i < NREGS; i++)
         rf_d[i] = (i != 0 && bus.wb_en && int'(bus.wb_addr) == i) ? bus.wb_data : rf_q[i];
   end
   always_comb begin
      hazard = ex_q.valid && ex_q.mem_read && ex_q.rd != '0
               && ((use_rs1 && rs1 == ex_q.rd) || (use_rs2 && rs2 == ex_q.rd));
      accept = bus.if_valid && bus.if_ready;
      dec    = '{valid: 1'b1, pc: bus.if_pc, rs1_data: rs1_data, rs2_data: rs2_data, imm: imm,
                 rs1: rs1, rs2: rs2, rd: rd, opcode: op, funct3: ins[14:12], funct7_5: ins[30],
                 reg_write: has_rd && rd != '0 && !illegal, mem_read: is_load,
                 mem_write: is_store, illegal: illegal};
      ex_d   = ex_q;
      if (bus.flush)
         ex_d = '0;
      else if (accept)
         ex_d = dec;
      else if (ex_q.valid && !bus.ex_ready) begin
         // a stalled instruction picks up results written back while it waits
         if (BYPASS && bus.wb_en && bus.wb_addr != '0 && bus.wb_addr == ex_q.rs1)
            ex_d.rs1_data = bus.wb_data;
         if (BYPASS && bus.wb_en && bus.wb_addr != '0 && bus.wb_addr == ex_q.rs2)
            ex_d.rs2_data = bus.wb_data;
      end
      else
         ex_d = '0;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_q <= '0;
         for (int i = 0; i < NREGS; i++)
            rf_q[i] <= '0;
      end
      else begin
         ex_q <= ex_d;
         rf_q <= rf_d;
      end
   end
   assign bus.if_ready     = (!ex_q.valid || bus.ex_ready) && !hazard && !bus.flush;
   assign bus.hazard_stall = hazard;
   assign bus.ex_valid     = ex_q.valid;
   assign bus.ex_pc        = ex_q.pc;
   assign bus.ex_rs1_data  = ex_q.rs1_data;
   assign bus.ex_rs2_data  = ex_q.rs2_data;
   assign bus.ex_imm       = ex_q.imm;
   assign bus.ex_rs1       = ex_q.rs1;
   assign bus.ex_rs2       = ex_q.rs2;
   assign bus.ex_rd        = ex_q.rd;
   assign bus.ex_opcode    = ex_q.opcode;
   assign bus.ex_funct3    = ex_q.funct3;
   assign bus.ex_funct7_5  = ex_q.funct7_5;
   assign bus.ex_reg_write = ex_q.reg_write;
   assign bus.ex_mem_read  = ex_q.mem_read;
   assign bus.ex_mem_write = ex_q.mem_write;
   assign bus.ex_illegal   = ex_q.illegal;
endmodule
